uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_transmitter.sv | 139 +++++++++++++
 tb/tb_uart_transmitter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, bit timing helper and transmitter state encoding
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT = 100_000_000;
    localparam int FRAME_BITS_8N1   = 10;
    localparam int FRAME_BITS_8E1   = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even-rounded bit period; the receiver uses the same rounding so both ends stay aligned.
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return 2 * (clk_hz / baud / 2);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with a one-cycle tick on the last cycle of each bit
module uart_baud_tick #(
    parameter int BIT_CYCLES = 10416
) (
    input  logic clk_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN for an even parity bit (8E1)
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int BRate    = 9600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       t
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BRate);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       t_q, t_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    // Holding the counter clear in IDLE means every frame starts from a fresh bit period.
    uart_baud_tick #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud_tick (
        .clk_i  (CLK),
        .clear_i(RST || state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        t_d       = t_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                t_d    = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_idx_d = 3'd0;
                    t_d       = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    t_d     = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        t_d     = parity_q;
`else
                        state_d = STOP;
                        t_d     = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        t_d       = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    t_d     = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    t_d     = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            t_q       <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            t_q       <= t_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign t       = t_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench: driver queues expected bytes, line monitor checks every cycle of each frame
module tb_uart_transmitter;
    import uart_pkg::*;

    // 1.7 MHz / 100 kBd = 17, rounded down to an even 16 cycles per bit.
    localparam int CLK_FREQ = 1_700_000;
    localparam int BRATE    = 100_000;
    localparam int B        = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = FRAME_BITS_8E1;
`else
    localparam int NB = FRAME_BITS_8N1;
`endif
    localparam int LIMIT = 20 * B;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_busy;
    logic       tx_done;
    logic       t;

    uart_transmitter #(
        .CLK_FREQ(CLK_FREQ),
        .BRate   (BRATE)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .t       (t)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    bit rst_applied = 1'b1;
    always @(posedge CLK) begin
        cyc         <= cyc + 1;
        rst_applied <= RST;
    end

    typedef struct {
        logic [7:0] data;
        bit         b2b;
        bit         abort;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
        logic [NB-1:0] f;
`ifdef UART_TX_PARITY_EN
        f = {1'b1, ^d, d, 1'b0};
`else
        f = {1'b1, d, 1'b0};
`endif
        return f;
    endfunction

    // Line monitor: aligns on the start bit and checks every cycle of the frame.
    logic [NB-1:0] frame;
    exp_t          cur;
    bit            in_frame = 1'b0;
    bit            bit_bad  = 1'b0;
    int            pos      = 0;
    int            last_done = -100;

    always @(negedge CLK) begin
        if (rst_applied) begin
            if (in_frame) begin
                check("abort_was_expected", cur.abort, 1);
                check("rst_line_high", t, 1);
                check("rst_busy_low", tx_busy, 0);
                in_frame = 1'b0;
            end
        end else begin
            if (!in_frame) begin
                if (tx_done) check("done_outside_frame", tx_done, 0);
                if (t == 1'b0) begin
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        frame    = frame_of(cur.data);
                        in_frame = 1'b1;
                        pos      = 0;
                        bit_bad  = 1'b0;
                        if (cur.b2b) check("b2b_restart_gap", cyc - last_done, 1);
                    end
                end
            end
            if (in_frame) begin
                if (pos < NB * B) begin
                    if (t !== frame[pos / B] || tx_busy !== 1'b1 || tx_done !== 1'b0) bit_bad = 1'b1;
                    if (pos % B == B - 1) begin
                        check($sformatf("frame_%02h_bit%0d_bad", cur.data, pos / B), bit_bad, 0);
                        bit_bad = 1'b0;
                    end
                end else begin
                    check($sformatf("done_at_end_%02h", cur.data), tx_done, 1);
                    check("busy_low_at_done", tx_busy, 0);
                    check("abort_not_expected", cur.abort, 0);
                    last_done = cyc;
                    in_frame  = 1'b0;
                end
                pos++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit abort);
        @(negedge CLK);
        tx_data  = d;
        tx_start = 1'b1;
        exp_q.push_back('{data: d, b2b: 1'b0, abort: abort});
        @(negedge CLK);
        tx_start = 1'b0;
        tx_data  = ~d;
        check("accept_busy_high", tx_busy, 1);
        check("accept_start_bit", t, 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tx_done && n < LIMIT);
        check(name, tx_done, 1);
    endtask

    initial begin
        bit idle_bad;
        int n;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("reset_t", t, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);

        idle_bad = 1'b0;
        repeat (200) begin
            @(negedge CLK);
            if (t !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idle_bad = 1'b1;
        end
        check("idle_quiet", idle_bad, 0);

        send(8'h55, 1'b0);
        wait_done("done_55");

        // A start request mid-frame must be dropped, not queued.
        send(8'h96, 1'b0);
        repeat (3 * B) @(negedge CLK);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
        wait_done("done_96");
        repeat (3 * B) @(negedge CLK);
        check("ignored_not_queued", tx_busy, 0);

        // tx_start held high: each tx_done cycle accepts the next byte.
        @(negedge CLK);
        tx_data  = 8'hA3;
        tx_start = 1'b1;
        exp_q.push_back('{data: 8'hA3, b2b: 1'b0, abort: 1'b0});
        wait_done("done_A3");
        tx_data = 8'h00;
        exp_q.push_back('{data: 8'h00, b2b: 1'b1, abort: 1'b0});
        wait_done("done_00");
        tx_data = 8'hFF;
        exp_q.push_back('{data: 8'hFF, b2b: 1'b1, abort: 1'b0});
        wait_done("done_FF");
        tx_start = 1'b0;
        repeat (2 * B) @(negedge CLK);

        send(8'h5A, 1'b1);
        repeat (4 * B + B / 2 - 1) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (2 * B) @(negedge CLK);
        send(8'h81, 1'b0);
        wait_done("done_81");

        @(negedge CLK);
        RST      = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hEE;
        @(negedge CLK);
        RST      = 1'b0;
        tx_start = 1'b0;
        check("rst_start_busy", tx_busy, 0);
        check("rst_start_line", t, 1);
        repeat (2 * B) @(negedge CLK);

        send(8'h07, 1'b0);
        wait_done("done_07");
        send(8'h03, 1'b0);
        wait_done("done_03");

        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < LIMIT) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
